// File: rtl/tapline_mc.sv
// tapline_mc: multi-channel FIR tap delay line with round-robin interleave.
// Ports: clk, resetn, en, flush, d_valid, d -> q taps, q_valid, q_ch, q_primed.
module tapline_mc #(
  parameter  int WORD_WIDTH  = 16,
  parameter  int CHAIN_DEPTH = 53,
  parameter  int NUM_CH      = 2,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int FILL_W = $clog2(CHAIN_DEPTH + 1)
) (
  input  logic                                       clk,
  input  logic                                       resetn,
  input  logic                                       en,
  input  logic                                       flush,
  input  logic                                       d_valid,
  input  logic signed [WORD_WIDTH-1:0]               d,
  output logic [CHAIN_DEPTH-1:0][WORD_WIDTH-1:0]     q,
  output logic                                       q_valid,
  output logic [CH_W-1:0]                            q_ch,
  output logic                                       q_primed
);

  // The oldest tap of a chain is only ever discarded on the next shift,
  // so each channel keeps CHAIN_DEPTH-1 words of history; the full
  // post-shift chain lives in the q snapshot.
  typedef logic [CHAIN_DEPTH-2:0][WORD_WIDTH-1:0] hist_t;
  typedef logic [CHAIN_DEPTH-1:0][WORD_WIDTH-1:0] chain_t;

  hist_t             hist [NUM_CH];
  logic [FILL_W-1:0] fill [NUM_CH];
  logic [CH_W-1:0]   ch_ptr;

  hist_t             cur_hist;
  logic [FILL_W-1:0] cur_fill;
  logic [FILL_W:0]   fill_inc;
  logic              primed_n;
  logic              acc;
  chain_t            nxt;
  logic [CH_W-1:0]   ptr_n;

  assign acc = en & d_valid & ~flush;

  always_comb begin
    cur_hist = '0;
    cur_fill = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_ptr == CH_W'(c)) begin
        cur_hist = hist[c];
        cur_fill = fill[c];
      end
    end
  end

  // One extra bit so fill+1 cannot wrap before the compare.
  assign fill_inc = {1'b0, cur_fill} + {{FILL_W{1'b0}}, 1'b1};
  assign primed_n = fill_inc >= (FILL_W + 1)'(CHAIN_DEPTH);
  assign nxt      = {cur_hist, d};
  assign ptr_n    = (ch_ptr == CH_W'(NUM_CH - 1)) ?
                    '0 : ch_ptr + {{(CH_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        hist[c] <= '0;
        fill[c] <= '0;
      end
      ch_ptr   <= '0;
      q        <= '0;
      q_ch     <= '0;
      q_valid  <= 1'b0;
      q_primed <= 1'b0;
    end else if (flush) begin
      for (int c = 0; c < NUM_CH; c++) begin
        hist[c] <= '0;
        fill[c] <= '0;
      end
      ch_ptr   <= '0;
      q        <= '0;
      q_ch     <= '0;
      q_valid  <= 1'b0;
      q_primed <= 1'b0;
    end else begin
      q_valid <= acc;
      if (acc) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_ptr == CH_W'(c)) begin
            hist[c] <= nxt[CHAIN_DEPTH-2:0];
            fill[c] <= primed_n ? FILL_W'(CHAIN_DEPTH)
                                : fill_inc[FILL_W-1:0];
          end
        end
        q        <= nxt;
        q_ch     <= ch_ptr;
        q_primed <= primed_n;
        ch_ptr   <= ptr_n;
      end
    end
  end

endmodule

// File: tb/tb_tapline_mc.sv
// tb_tapline_mc: directed bench for tapline_mc with 1, 2 and 3 channels.
// Shared stimulus drives all three instances; each scenario checks one.
module tb_tapline_mc;

  localparam int W = 16;
  localparam int D = 53;

  logic clk = 1'b0;
  logic resetn, en, flush, dv;
  logic signed [W-1:0] d;

  logic [D-1:0][W-1:0] q1, q2, q3;
  logic qv1, qv2, qv3;
  logic [0:0] qc1, qc2;
  logic [1:0] qc3;
  logic pr1, pr2, pr3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tapline_mc #(.WORD_WIDTH(W), .CHAIN_DEPTH(D), .NUM_CH(1)) u1 (
    .clk(clk), .resetn(resetn), .en(en), .flush(flush),
    .d_valid(dv), .d(d), .q(q1), .q_valid(qv1), .q_ch(qc1),
    .q_primed(pr1));

  tapline_mc #(.WORD_WIDTH(W), .CHAIN_DEPTH(D), .NUM_CH(2)) u2 (
    .clk(clk), .resetn(resetn), .en(en), .flush(flush),
    .d_valid(dv), .d(d), .q(q2), .q_valid(qv2), .q_ch(qc2),
    .q_primed(pr2));

  tapline_mc #(.WORD_WIDTH(W), .CHAIN_DEPTH(D), .NUM_CH(3)) u3 (
    .clk(clk), .resetn(resetn), .en(en), .flush(flush),
    .d_valid(dv), .d(d), .q(q3), .q_valid(qv3), .q_ch(qc3),
    .q_primed(pr3));

  typedef struct {
    logic        en;
    logic        dv;
    logic        fl;
    logic [15:0] d;
    logic        qv;
    logic [1:0]  ch;
    logic [15:0] q0;
    logic [15:0] q1;
    logic        pr;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(logic e, logic v, logic f,
                              logic [15:0] dd, logic xv,
                              logic [1:0] xc, logic [15:0] x0,
                              logic [15:0] x1, logic xp);
    vec_t r;
    r.en = e; r.dv = v; r.fl = f; r.d = dd;
    r.qv = xv; r.ch = xc; r.q0 = x0; r.q1 = x1; r.pr = xp;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkq(input string nm, input logic [D*W-1:0] act,
                      input logic [D*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    en = 1'b0; dv = 1'b0; flush = 1'b0; d = '0;
    cyc();
    resetn = 1'b1;
  endtask

  task automatic push(input logic [15:0] v);
    en = 1'b1; dv = 1'b1; flush = 1'b0; d = v;
    cyc();
  endtask

  logic [D*W-1:0] allx;

  initial begin
    resetn = 1'b0;
    en = 1'b0; dv = 1'b0; flush = 1'b0; d = '0;
    #2;
    chkq("reset q", q2, '0);
    chk("reset qv", {qv1, qv2, qv3}, 0);
    chk("reset qch", {qc1, qc2, qc3}, 0);
    chk("reset primed", {pr1, pr2, pr3}, 0);
    do_reset();

    // Single channel: d = 0, -1, ... -59
    for (int k = 0; k < 60; k++) begin
      push(16'(-k));
      chk($sformatf("A primed k=%0d", k), pr1, (k >= 52) ? 1 : 0);
    end
    chk("A q0", q1[0], 16'hFFC5);
    chk("A q52", q1[52], 16'hFFF9);
    chk("A qch", qc1, 0);

    // Two-channel interleave
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      push(16'(k));
      if (k == 9) begin
        chk("B9 qch", qc2, 0);
        chk("B9 q0", q2[0], 9);
        chk("B9 q1", q2[1], 7);
        chk("B9 q4", q2[4], 1);
        chk("B9 q5", q2[5], 0);
      end
      if (k == 10) begin
        chk("B10 qch", qc2, 1);
        chk("B10 q0", q2[0], 10);
        chk("B10 q4", q2[4], 2);
      end
    end

    // Stall / gaps / flush table on the 3-channel instance
    tbl[0]  = mk(0, 1, 0, 11, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 12, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 13, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 14, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 1, 0, 21, 1, 0, 21, 0, 0);
    tbl[5]  = mk(1, 0, 0, 99, 0, 0, 21, 0, 0);
    tbl[6]  = mk(1, 1, 0, 22, 1, 1, 22, 0, 0);
    tbl[7]  = mk(0, 1, 0, 98, 0, 1, 22, 0, 0);
    tbl[8]  = mk(1, 1, 0, 23, 1, 2, 23, 0, 0);
    tbl[9]  = mk(1, 0, 0, 97, 0, 2, 23, 0, 0);
    tbl[10] = mk(1, 1, 0, 24, 1, 0, 24, 21, 0);
    tbl[11] = mk(1, 1, 1, 77, 0, 0, 0, 0, 0);
    tbl[12] = mk(1, 1, 0, 5, 1, 0, 5, 0, 0);
    do_reset();
    for (int i = 0; i < 13; i++) begin
      en = tbl[i].en; dv = tbl[i].dv; flush = tbl[i].fl; d = tbl[i].d;
      cyc();
      chk($sformatf("T%0d qv", i), qv3, tbl[i].qv);
      chk($sformatf("T%0d qch", i), qc3, tbl[i].ch);
      chk($sformatf("T%0d q0", i), q3[0], tbl[i].q0);
      chk($sformatf("T%0d q1", i), q3[1], tbl[i].q1);
      chk($sformatf("T%0d primed", i), pr3, tbl[i].pr);
    end

    // Flush after 7 samples on the 2-channel instance
    do_reset();
    for (int k = 1; k <= 7; k++) push(16'(k));
    en = 1'b1; dv = 1'b1; flush = 1'b1; d = 16'd77;
    cyc();
    chkq("F q", q2, '0);
    chk("F qv", qv2, 0);
    chk("F qch", qc2, 0);
    chk("F primed", pr2, 0);
    push(16'd5);
    chk("F2 qv", qv2, 1);
    chk("F2 qch", qc2, 0);
    chk("F2 q0", q2[0], 5);
    chk("F2 q1", q2[1], 0);
    chk("F2 primed", pr2, 0);

    // Asynchronous reset between edges
    for (int k = 0; k < 6; k++) push(16'(100 + k));
    chk("R pre qv", qv2, 1);
    en = 1'b0; dv = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chkq("R q", q2, '0);
    chk("R qv", qv2, 0);
    chk("R qch", qc2, 0);
    #1;
    resetn = 1'b1;
    for (int k = 1; k <= 106; k++) begin
      push(16'(k));
      if (k == 1) chk("R first ch", qc2, 0);
      if (k == 104) chk("R primed 104", pr2, 0);
      if (k == 105) chk("R primed 105", pr2, 1);
      if (k == 106) chk("R primed 106", pr2, 1);
    end

    // Saturation with extreme values
    do_reset();
    for (int k = 0; k < 200; k++) begin
      push((k % 2 == 0) ? 16'h7FFF : 16'h8000);
      chk($sformatf("S q0 k=%0d", k), q2[0],
          (k % 2 == 0) ? 16'h7FFF : 16'h8000);
      chk($sformatf("S primed k=%0d", k), pr2, (k >= 104) ? 1 : 0);
    end
    allx = {D{16'h8000}};
    chkq("S ch1 chain", q2, allx);
    chk("S qch", qc2, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/tapline_mc.md
# tapline_mc

Multi-channel, parametrised FIR tap delay line. It holds `NUM_CH` independent shift chains, each `CHAIN_DEPTH` words deep. Input samples arrive round-robin interleaved across channels. Each accepted sample shifts only its own channel's chain, and a registered snapshot of that chain's taps is presented to the downstream MAC. It sits between the sample source and the coefficient multiply/accumulate stage, and generalises the single-channel `shiftchain` with three additions: channel interleaving, a valid handshake, and flush/primed tracking.

## Interface
Parameters:
- `WORD_WIDTH`, 16, width of one signed sample.
- `CHAIN_DEPTH`, 53, number of taps per channel; must be ≥ 2.
- `NUM_CH`, 2, number of interleaved channels; must be ≥ 1.
- Derived, not overridable: `CH_W` = max(1, $clog2(NUM_CH)); `FILL_W` = $clog2(CHAIN_DEPTH+1).

Ports:
- `clk`  in  1  sole clock, rising-edge.
- `resetn`  in  1  reset, asynchronous assert, active-low.
- `en`  in  1  global enable; 0 stalls sample acceptance.
- `flush`  in  1  synchronous clear of all chains and state.
- `d_valid`  in  1  `d` carries a sample for the current channel.
- `d`  in  `WORD_WIDTH`  signed input sample.
- `q`  out  `CHAIN_DEPTH` x `WORD_WIDTH` (packed `[CHAIN_DEPTH-1:0][WORD_WIDTH-1:0]`)  tap snapshot; `q[0]` is the newest sample.
- `q_valid`  out  1  one-cycle pulse; `q`, `q_ch` and `q_primed` are valid.
- `q_ch`  out  `CH_W`  channel index of the snapshot.
- `q_primed`  out  1  snapshot channel has had ≥ `CHAIN_DEPTH` samples since the last reset or flush.

## Operation
- Storage: `tap[c][i]` for c in 0..NUM_CH-1 and i in 0..CHAIN_DEPTH-1. Per-channel `fill[c]` (`FILL_W` bits). Channel pointer `ch_ptr` (`CH_W` bits).
- Accept condition: `acc = en & d_valid & ~flush`.
- On `acc`, with c = `ch_ptr`:
  - Shift: `tap[c][0] <= d`, and `tap[c][i] <= tap[c][i-1]` for i ≥ 1. The oldest word is discarded. All other channels hold.
  - Snapshot: `q[0] <= d` and `q[i] <= old tap[c][i-1]`, so `q` equals the post-shift chain.
  - `q_ch <= c`; `q_valid <= 1`.
  - `fill[c] <= min(fill[c]+1, CHAIN_DEPTH)` (saturating).
  - `q_primed <= (fill[c]+1 >= CHAIN_DEPTH)`.
  - `ch_ptr <= (c == NUM_CH-1) ? 0 : c+1`. When NUM_CH = 1, `ch_ptr` stays 0.
- Cycles without `acc` and without `flush`:
  - `q_valid <= 0`.
  - `q`, `q_ch`, `q_primed`, all taps, `fill` and `ch_ptr` hold.
  - A `d_valid` pulse while `en` = 0 is dropped and does not advance `ch_ptr`.
- `flush` = 1 has priority over `en` and `d_valid`. On the next edge it clears all taps, `fill`, `ch_ptr`, `q`, `q_ch`, `q_valid` and `q_primed` to 0. The sample presented in that cycle is dropped.
- Arithmetic: pure storage, no sign extension or truncation. Values are passed bit-exact as two's complement.

## Timing
- Reset (`resetn` = 0, asynchronous): all taps, `fill`, `ch_ptr`, `q` (all words), `q_ch`, `q_valid` and `q_primed` go to 0 immediately. Release is synchronous to the next `clk` edge.
- Reset asserted mid-stream clears state within the same cycle. The first accepted sample after release goes to channel 0.
- Latency: a sample accepted at edge N appears in `q[0]`, with `q_valid` = 1, after edge N.
- Throughput: one sample per cycle, no bubbles required. Back-to-back accepts produce back-to-back `q_valid` pulses on successive channels.
- Wrap-around: after channel NUM_CH-1 is accepted, the next accept targets channel 0.
- Saturation: `fill` stops at `CHAIN_DEPTH`; `q_primed` stays 1 for that channel until reset or flush.
- `flush` and `resetn` released together: reset dominates.

## Test plan
- **Single channel:** NUM_CH=1, defaults otherwise. Reset, then `en`=`d_valid`=1 and feed d = 0, -1, …, -59 on consecutive cycles.
  - After the last edge: `q[0]` = -59, `q[52]` = -7, `q_ch` = 0.
  - `q_primed` first rises on the 53rd sample (d = -52) and stays high.
- **Two-channel interleave:** NUM_CH=2. Feed d = 1..10 continuously.
  - The snapshot with d = 9 shows `q_ch`=0, `q[0]`=9, `q[1]`=7, `q[4]`=1, `q[5]`=0.
  - The snapshot with d = 10 shows `q_ch`=1, `q[0]`=10, `q[4]`=2.
- **Stall:** NUM_CH=3.
  - Drive `d_valid`=1 with `en`=0 for 4 cycles: no `q_valid`, `ch_ptr` unchanged.
  - Then insert `d_valid` gaps: every `q_valid` pulse follows exactly one accepted edge, and `q_ch` runs 0,1,2,0.
- **Flush mid-stream:**
  - Flush after 7 samples: next cycle all outputs are 0 and the sample presented with `flush` is lost.
  - The next sample lands in channel 0 with `q[1]` = 0 and `q_primed` = 0.
- **Asynchronous reset mid-stream:**
  - Pulse `resetn` low between clock edges: `q`, `q_valid` and `q_ch` read 0 before the next edge.
  - Re-fill to 53 samples per channel: `q_primed` reasserts.
- **Saturation and extremes:** NUM_CH=2, with alternating samples 0x7FFF and 0x8000 for 200 samples.
  - Bits pass unchanged.
  - `fill` saturates at 53 without wrapping, and `q_primed` never drops.
